// File: rtl/conv_maxpool_requant_pkg.sv
// conv_maxpool_requant_pkg
//   Shared definitions for the max-pool / requantize stage and its helpers:
//   default frame geometry, the FSM state encoding and the saturation limits
//   used when squeezing wide signed results into an unsigned pixel.
package conv_maxpool_requant_pkg;

  localparam int COLS_DEF   = 224;
  localparam int ROWS_DEF   = 224;
  localparam int ADDR_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lower saturation limit of an unsigned pixel.
  localparam longint SAT_LO = 0;

  // Upper saturation limit of an unsigned pixel of the given width.
  function automatic longint sat_hi(input int out_w);
    return (longint'(1) << out_w) - 1;
  endfunction

endpackage

// File: rtl/conv_maxpool_requant_requant.sv
// requant_sat
//   Pure combinational requantizer: arithmetic right shift of a signed value,
//   then clamp into [0, 2^OUT_W-1].
//   Optional build macro CONV_MAXPOOL_ROUND_EN: adds half an LSB before the
//   shift (round half-up). The sum is formed at IN_W+1 bits so it cannot wrap.
// Ports:
//   din  : signed IN_W-bit input
//   dout : unsigned OUT_W-bit saturated result
module requant_sat
  import conv_maxpool_requant_pkg::*;
#(
  parameter int IN_W  = 36,
  parameter int OUT_W = 9,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0] din,
  output logic        [OUT_W-1:0] dout
);

  localparam logic signed [IN_W:0] HI = (IN_W+1)'(sat_hi(OUT_W));
  localparam logic signed [IN_W:0] LO = (IN_W+1)'(SAT_LO);
`ifdef CONV_MAXPOOL_ROUND_EN
  // With no shift there is nothing to round, so the bias collapses to zero.
  localparam int                   HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] HALF     = (SHIFT > 0) ? ((IN_W+1)'(1) << HALF_POS) : '0;
`endif

  logic signed [IN_W:0] wide;
  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] q;

  always_comb begin
    wide = {din[IN_W-1], din};
`ifdef CONV_MAXPOOL_ROUND_EN
    biased = wide + HALF;
`else
    biased = wide;
`endif
    q = biased >>> SHIFT;
    if (q < LO) begin
      dout = '0;
    end else if (q > HI) begin
      dout = HI[OUT_W-1:0];
    end else begin
      dout = q[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/conv_maxpool_requant.sv
// conv_maxpool_requant
//   2x2 stride-2 max pooling over a COLS x ROWS stream of signed conv results,
//   followed by requantization to OUT_W-bit unsigned (see requant_sat).
//   Optional build macro CONV_MAXPOOL_ROUND_EN selects round-half-up
//   requantization; default is a truncating shift.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : arms one frame (only honoured in IDLE)
//   in_valid    : sample strobe, accepted only while RUN
//   in_data     : signed IN_W-bit sample
//   out_valid   : single-cycle pooled pixel strobe
//   out_data    : requantized pixel
//   out_addr    : row-major linear address of the pooled pixel
//   busy        : high while RUN
//   frame_done  : one-cycle pulse in the DONE state after the last pixel
module conv_maxpool_requant
  import conv_maxpool_requant_pkg::*;
#(
  parameter int IN_W   = 36,
  parameter int OUT_W  = 9,
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int SHIFT  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  state_t state_reg, state_next;

  logic [CW-1:0]          col_reg;
  logic [RW-1:0]          row_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic signed [IN_W-1:0] hold_reg;
  logic signed [IN_W-1:0] linebuf [COLS/2];
  logic signed [IN_W-1:0] hmax;
  logic signed [IN_W-1:0] pmax;
  logic [CW-2:0]          lb_idx;
  logic [OUT_W-1:0]       q;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;
  logic                   emit;

  assign accept   = in_valid && (state_reg == RUN);
  assign col_last = (col_reg == CW'(COLS-1));
  assign row_last = (row_reg == RW'(ROWS-1));
  // Each horizontal pair maps to one line-buffer slot.
  assign lb_idx   = col_reg[CW-1:1];
  // Bottom-right sample of a 2x2 window completes a pooled pixel.
  assign emit     = accept && col_reg[0] && row_reg[0];

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && col_last && row_last) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_reg  <= '0;
      row_reg  <= '0;
      addr_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      col_reg  <= '0;
      row_reg  <= '0;
      addr_reg <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
      if (emit) addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

  // Datapath storage carries no reset: contents are only consumed after
  // being written earlier in the same frame.
  always_ff @(posedge clk) begin
    if (accept && !col_reg[0]) hold_reg <= in_data;
    if (accept && col_reg[0] && !row_reg[0]) linebuf[lb_idx] <= hmax;
  end

  assign hmax = (hold_reg > in_data) ? hold_reg : in_data;
  assign pmax = (linebuf[lb_idx] > hmax) ? linebuf[lb_idx] : hmax;

  requant_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .din  (pmax),
    .dout (q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_data <= q;
        out_addr <= addr_reg;
      end
    end
  end

endmodule
